uart_time_set_rx: RTL and testbench

//  UART receiver and command parser for the clock's serial time-set path.

---
 rtl/uart_time_set_rx.sv | 147 ++++++++++++++
 tb/tb_uart_time_set_rx.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/uart_time_set_rx.sv
// uart_time_set_rx: 8N1 UART receiver that parses "T"+HHMMSS+CR|LF into a validated time load strobe
module uart_time_set_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [6:0] set_hour,
  output logic [6:0] set_min,
  output logic [6:0] set_sec,
  output logic       set_valid,
  output logic       frame_err,
  output logic       cmd_err,
  output logic       busy
);
  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int HALF = BIT_CYC / 2;
  localparam int CW = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1 = CW'(BIT_CYC - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_t;
  typedef enum logic [2:0] {WAIT_T, DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, WAIT_END} ps_t;

  rx_t st, st_n;
  ps_t ps, ps_n;
  logic rx_m, rx_s, rx_d;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic byte_ok, ferr, load, cerr, wr;
  logic [3:0] d [6];
  logic [6:0] hour, min, sec;
  logic is_t, is_dig, is_end, legal;

  function automatic logic [6:0] ten(input logic [3:0] x);
    return {x, 3'b000} + {2'b00, x, 1'b0};
  endfunction

  // Synchronise rx and keep its previous value for start-edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_m, rx_s, rx_d} <= 3'b111;
    else {rx_m, rx_s, rx_d} <= {rx, rx_m, rx_s};

  // Receive FSM state, bit counter and shift register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
    end

  // Receive FSM next state: mid-bit sampling, byte_ok/ferr on the stop-bit sample
  always_comb begin
    st_n = st;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    byte_ok = 1'b0;
    ferr = 1'b0;
    case (st)
      IDLE: begin
        cnt_n = '0;
        if (rx_d && !rx_s) st_n = START;
      end
      START: if (cnt == HALF_M1) begin
        cnt_n = '0;
        idx_n = '0;
        st_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == BIT_M1) begin
        cnt_n = '0;
        sh_n = {rx_s, sh[7:1]};
        idx_n = idx + 3'd1;
        if (idx == 3'd7) st_n = STOP;
      end
      default: if (cnt == BIT_M1) begin
        st_n = IDLE;
        byte_ok = rx_s;
        ferr = !rx_s;
      end
    endcase
  end

  assign is_t = sh == 8'h54;
  assign is_dig = sh >= 8'h30 && sh <= 8'h39;
  assign is_end = sh == 8'h0D || sh == 8'h0A;
  assign hour = ten(d[0]) + {3'b000, d[1]};
  assign min = ten(d[2]) + {3'b000, d[3]};
  assign sec = ten(d[4]) + {3'b000, d[5]};
  assign legal = hour <= 7'd23 && min <= 7'd59 && sec <= 7'd59;
  assign busy = st != IDLE || ps != WAIT_T;

  // Parser next state: 'T' always restarts, framing errors abort the command
  always_comb begin
    ps_n = ps;
    load = 1'b0;
    cerr = 1'b0;
    wr = 1'b0;
    if (ferr) ps_n = WAIT_T;
    else if (byte_ok)
      case (ps)
        WAIT_T: ps_n = is_t ? DIG0 : WAIT_T;
        WAIT_END: begin
          ps_n = is_t ? DIG0 : WAIT_T;
          load = is_end && legal;
          cerr = !is_t && !(is_end && legal);
        end
        default: begin
          ps_n = is_t ? DIG0 : is_dig ? ps_t'(ps + 3'd1) : WAIT_T;
          wr = is_dig;
          cerr = !is_t && !is_dig;
        end
      endcase
  end

  // Parser state, digit store and registered output strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ps <= WAIT_T;
      for (int i = 0; i < 6; i++) d[i] <= '0;
      set_hour <= '0;
      set_min <= '0;
      set_sec <= '0;
      set_valid <= 1'b0;
      frame_err <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      ps <= ps_n;
      for (int i = 0; i < 6; i++) if (wr && ps == ps_t'(i + 1)) d[i] <= sh[3:0];
      set_valid <= load;
      frame_err <= ferr;
      cmd_err <= cerr;
      if (load) begin
        set_hour <= hour;
        set_min <= min;
        set_sec <= sec;
      end
    end
endmodule

// File: tb/tb_uart_time_set_rx.sv
// tb_uart_time_set_rx: directed scoreboard bench for the UART time-set receiver
module tb_uart_time_set_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic [6:0] set_hour, set_min, set_sec;
  logic set_valid, frame_err, cmd_err, busy;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {int k; int h; int m; int s;} ev_t;
  ev_t q[$];

  uart_time_set_rx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_valid(set_valid), .frame_err(frame_err), .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input int h, input int m, input int s);
    ev_t e;
    e.k = k; e.h = h; e.m = m; e.s = s;
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = stop;
    repeat (10) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk(tag, q.size(), 0);
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"}, int'(set_hour), h);
    chk({tag, "_min"}, int'(set_min), m);
    chk({tag, "_sec"}, int'(set_sec), s);
  endtask

  // Every output pulse must match the oldest expected event (0=valid, 1=cmd_err, 2=frame_err)
  always @(negedge clk)
    if (rst_n && (set_valid || cmd_err || frame_err)) begin
      chk("exclusive", int'(set_valid) + int'(cmd_err) + int'(frame_err), 1);
      if (q.size() == 0) chk("unexpected_pulse", q.size(), 1);
      else begin
        ev_t e;
        e = q.pop_front();
        chk("kind", set_valid ? 0 : cmd_err ? 1 : 2, e.k);
        if (e.k == 0) chk_time("load", e.h, e.m, e.s);
      end
    end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'({set_valid, frame_err, cmd_err}), 0);
    chk_time("rst", 0, 0, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    push(0, 12, 34, 56);
    send_str("T123456\r");
    drain("t1_drain");
    chk_time("t1", 12, 34, 56);

    push(0, 23, 59, 59);
    send_str("T235959\n");
    push(1, 0, 0, 0);
    send_str("T240000\r");
    drain("t2_drain");
    chk_time("t2_hold", 23, 59, 59);

    send_str("T12");
    push(2, 0, 0, 0);
    send_byte(8'h33, 1'b0);
    repeat (20) @(negedge clk);
    chk("t3_busy", int'(busy), 0);
    push(0, 0, 0, 0);
    send_str("T000000\r");
    drain("t3_drain");
    chk_time("t3", 0, 0, 0);

    rx = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_busy_hi", int'(busy), 1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_busy_lo", int'(busy), 0);
    chk("glitch_q", q.size(), 0);

    push(0, 8, 15, 0);
    send_str("T12T081500\r");
    drain("t5_drain");
    chk_time("t5", 8, 15, 0);

    send_str("T12");
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_time("t6_rst", 0, 0, 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_pulses", int'({set_valid, frame_err, cmd_err}), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    push(0, 1, 2, 3);
    send_str("T010203\r");
    drain("t6_drain");
    chk_time("t6", 1, 2, 3);
    chk("final_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
